// File: rtl/riscuin_bus_pkg.sv
// Shared types, size encodings and the alignment helper for the data bus arbiter.
package riscuin_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester, bus-controller and status signals of the data bus arbiter.
// The arbiter uses the slave view; requesters and the bus model use the master view.
interface data_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                  m0_req;
  logic                  m0_we;
  logic [1:0]            m0_size;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [1:0]            m1_size;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  s_wd;
  logic                  s_rd;
  logic [1:0]            s_size;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_ready;
  logic                  s_busy;

  logic                  owner;
  logic                  timeout;

  modport slave (
    input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output s_wd, s_rd, s_size, s_addr, s_wdata,
    input  s_rdata, s_ready, s_busy,
    output owner, timeout
  );

  modport master (
    output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  s_wd, s_rd, s_size, s_addr, s_wdata,
    output s_rdata, s_ready, s_busy,
    input  owner, timeout
  );

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational two-way round-robin pick: on contention the requester that
// does not currently own the bus wins.
module bus_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic grant_valid,
  output logic winner
);

  // Winner selection; winner is don't-care (driven 0) when nobody requests.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~owner;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the data bus controller port.
// Issues one strobe per transaction, rejects illegal accesses, bounds stalls with a timeout.
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input logic               clk,
  input logic               rst,
  data_bus_arbiter_if.slave bus
);

  import riscuin_bus_pkg::*;

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t            state_r;
  arb_state_t            state_s;

  logic                  grant_valid_s;
  logic                  winner_s;
  logic                  sel_we_s;
  logic [1:0]            sel_size_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  illegal_s;

  logic                  load_s;
  logic                  cnt_clr_s;
  logic                  cnt_inc_s;
  logic                  done_s;
  logic                  tmo_s;

  logic                  owner_r;
  logic                  we_r;
  logic [1:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  s_wd_r;
  logic                  s_rd_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  err0_r;
  logic                  err1_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;
  logic                  timeout_r;

  bus_rr_picker u_picker (
    .req0        (bus.m0_req),
    .req1        (bus.m1_req),
    .owner       (owner_r),
    .grant_valid (grant_valid_s),
    .winner      (winner_s)
  );

  // Route the winning requester's fields toward the latch.
  always_comb begin
    if (winner_s) begin
      sel_we_s    = bus.m1_we;
      sel_size_s  = bus.m1_size;
      sel_addr_s  = bus.m1_addr;
      sel_wdata_s = bus.m1_wdata;
    end else begin
      sel_we_s    = bus.m0_we;
      sel_size_s  = bus.m0_size;
      sel_addr_s  = bus.m0_addr;
      sel_wdata_s = bus.m0_wdata;
    end
  end

  assign illegal_s = (sel_size_s == SZ_ILLEGAL) || is_misaligned(sel_size_s, sel_addr_s[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; completion is tested before the timeout so it wins a tie.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    done_s    = 1'b0;
    tmo_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          load_s = 1'b1;
          if (illegal_s) begin
            state_s = RESP;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_clr_s = 1'b1;
        state_s   = WAIT;
      end
      WAIT: begin
        if (bus.s_ready && !bus.s_busy) begin
          done_s  = 1'b1;
          state_s = RESP;
        end else if (cnt_r == CNT_MAX) begin
          tmo_s   = 1'b1;
          state_s = RESP;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Transaction latch: fields stay put from the grant until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r <= 1'b1;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (load_s) begin
      owner_r <= winner_s;
      we_r    <= sel_we_s;
      size_r  <= sel_size_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
    end
  end

  // Response status and data; stores and failures return zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r   <= 1'b0;
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (load_s) begin
      err_r   <= illegal_s;
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (done_s) begin
      err_r   <= 1'b0;
      rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : bus.s_rdata;
    end else if (tmo_s) begin
      err_r   <= 1'b1;
      rdata_r <= {DATA_WIDTH{1'b0}};
    end
  end

  // Stall counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      timeout_r <= timeout_r | tmo_s;
    end
  end

  // Bus strobes: a single pulse following the ISSUE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_wd_r <= 1'b0;
      s_rd_r <= 1'b0;
    end else begin
      s_wd_r <= (state_r == ISSUE) && we_r;
      s_rd_r <= (state_r == ISSUE) && !we_r;
    end
  end

  // Per-requester completion pulses; rdata holds until that requester's next ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= {DATA_WIDTH{1'b0}};
      rdata1_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ack0_r <= (state_r == RESP) && !owner_r;
      ack1_r <= (state_r == RESP) && owner_r;
      err0_r <= (state_r == RESP) && !owner_r && err_r;
      err1_r <= (state_r == RESP) && owner_r && err_r;
      if ((state_r == RESP) && !owner_r) begin
        rdata0_r <= rdata_r;
      end
      if ((state_r == RESP) && owner_r) begin
        rdata1_r <= rdata_r;
      end
    end
  end

  assign bus.s_wd     = s_wd_r;
  assign bus.s_rd     = s_rd_r;
  assign bus.s_size   = size_r;
  assign bus.s_addr   = addr_r;
  assign bus.s_wdata  = wdata_r;
  assign bus.m0_ack   = ack0_r;
  assign bus.m0_err   = err0_r;
  assign bus.m0_rdata = rdata0_r;
  assign bus.m1_ack   = ack1_r;
  assign bus.m1_err   = err1_r;
  assign bus.m1_rdata = rdata1_r;
  assign bus.owner    = owner_r;
  assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: expected responses are queued when a request
// is driven and compared against each ack, including latency and strobe activity.
module tb_data_bus_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 15;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          n_rd;
    int          n_wd;
    logic [11:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  logic        clk;
  logic        rst;
  logic [11:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_wdata;

  data_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic err, input logic [31:0] rdata, input int lat,
                      input int n_rd, input int n_wd, input logic [11:0] addr,
                      input logic [1:0] size, input logic [31:0] wdata);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rdata; e.lat = lat; e.n_rd = n_rd; e.n_wd = n_wd;
    e.addr = addr; e.size = size; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic req(input logic id, input logic we, input logic [1:0] size,
                     input logic [11:0] addr, input logic [31:0] wdata);
    if (id) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_size = size; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_size = size; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic drop(input logic id);
    if (id) bus.m1_req = 1'b0;
    else    bus.m0_req = 1'b0;
  endtask

  // lat 0 is the edge that samples the request; release_at drops s_busy after that edge.
  task automatic wait_ack(input int max_cyc, input bit keep, input int release_at);
    int          lat;
    int          n_rd;
    int          n_wd;
    bit          got;
    exp_t        e;
    logic        obs_err;
    logic [31:0] obs_rdata;
    lat = -1; n_rd = 0; n_wd = 0; got = 1'b0;
    while (!got && lat < max_cyc) begin
      tick();
      lat++;
      if (lat == release_at) bus.s_busy = 1'b0;
      if (bus.s_rd === 1'b1) begin
        n_rd++; st_addr = bus.s_addr; st_size = bus.s_size; st_wdata = bus.s_wdata;
      end
      if (bus.s_wd === 1'b1) begin
        n_wd++; st_addr = bus.s_addr; st_size = bus.s_size; st_wdata = bus.s_wdata;
      end
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        got = 1'b1;
        check("ack_overlap", {31'd0, bus.m0_ack & bus.m1_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          obs_err   = e.id ? bus.m1_err : bus.m0_err;
          obs_rdata = e.id ? bus.m1_rdata : bus.m0_rdata;
          check("ack_id", {31'd0, bus.m1_ack}, {31'd0, e.id});
          check("ack_err", {31'd0, obs_err}, {31'd0, e.err});
          check("ack_rdata", obs_rdata, e.rdata);
          check("ack_latency", lat, e.lat);
          check("rd_strobes", n_rd, e.n_rd);
          check("wd_strobes", n_wd, e.n_wd);
          check("owner", {31'd0, bus.owner}, {31'd0, e.id});
          if (e.n_rd + e.n_wd > 0) begin
            check("strobe_addr", {20'd0, st_addr}, {20'd0, e.addr});
            check("strobe_size", {30'd0, st_size}, {30'd0, e.size});
          end
          if (e.n_wd > 0) check("strobe_wdata", st_wdata, e.wdata);
        end
        if (!keep) drop(bus.m1_ack);
      end
    end
    check("ack_wait_bound", {31'd0, got}, 32'd1);
  endtask

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_size = 2'b00; bus.m0_addr = 12'h000; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_size = 2'b00; bus.m1_addr = 12'h000; bus.m1_wdata = 32'h0;
    bus.s_rdata = 32'h0; bus.s_ready = 1'b0; bus.s_busy = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    exp_q.delete();
    tick();
    tick();
    check("rst_owner", {31'd0, bus.owner}, 32'd1);
    check("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
    check("rst_strobes", {30'd0, bus.s_rd, bus.s_wd}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    check("rst_addr", {20'd0, bus.s_addr}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();

    // Basic word load from requester 0.
    apply_reset();
    bus.s_ready = 1'b1; bus.s_busy = 1'b0; bus.s_rdata = 32'hDEADBEEF;
    push(1'b0, 1'b0, 32'hDEADBEEF, 3, 1, 0, 12'h010, 2'b10, 32'h0);
    req(1'b0, 1'b0, 2'b10, 12'h010, 32'h0);
    wait_ack(40, 1'b0, -1);
    tick();
    check("idle_after_drop", {29'd0, bus.s_rd, bus.s_wd, bus.m0_ack}, 32'd0);

    // Continuous contention alternates m0, m1, m0, m1.
    apply_reset();
    bus.s_ready = 1'b1; bus.s_busy = 1'b0; bus.s_rdata = 32'hCAFE0000;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'hCAFE0000, 3, 1, 0, 12'h020, 2'b10, 32'h0);
      push(1'b1, 1'b0, 32'h0, 3, 0, 1, 12'h024, 2'b10, 32'h11223344);
    end
    req(1'b0, 1'b0, 2'b10, 12'h020, 32'h0);
    req(1'b1, 1'b1, 2'b10, 12'h024, 32'h11223344);
    repeat (4) wait_ack(40, 1'b1, -1);
    drop(1'b0);
    drop(1'b1);

    // Rejections: misaligned half, illegal size, misaligned word.
    push(1'b1, 1'b1, 32'h0, 1, 0, 0, 12'h003, 2'b01, 32'h5555);
    req(1'b1, 1'b1, 2'b01, 12'h003, 32'h5555);
    wait_ack(40, 1'b0, -1);
    check("m0_rdata_hold", bus.m0_rdata, 32'hCAFE0000);
    push(1'b0, 1'b1, 32'h0, 1, 0, 0, 12'h000, 2'b11, 32'h0);
    req(1'b0, 1'b0, 2'b11, 12'h000, 32'h0);
    wait_ack(40, 1'b0, -1);
    push(1'b0, 1'b1, 32'h0, 1, 0, 0, 12'h002, 2'b10, 32'h0);
    req(1'b0, 1'b1, 2'b10, 12'h002, 32'h0);
    wait_ack(40, 1'b0, -1);

    // Timeout with s_busy held high.
    check("timeout_before", {31'd0, bus.timeout}, 32'd0);
    bus.s_busy = 1'b1; bus.s_rdata = 32'hBADBAD00;
    push(1'b0, 1'b1, 32'h0, 3 + MW, 1, 0, 12'h030, 2'b10, 32'h0);
    req(1'b0, 1'b0, 2'b10, 12'h030, 32'h0);
    wait_ack(40, 1'b0, -1);
    check("timeout_sticky", {31'd0, bus.timeout}, 32'd1);

    // Async reset in WAIT while the read strobe is high.
    bus.s_busy = 1'b1;
    req(1'b0, 1'b0, 2'b10, 12'h040, 32'h0);
    tick();
    tick();
    check("strobe_before_reset", {31'd0, bus.s_rd}, 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_strobe", {30'd0, bus.s_rd, bus.s_wd}, 32'd0);
    check("async_rst_addr", {20'd0, bus.s_addr}, 32'd0);
    check("async_rst_owner", {31'd0, bus.owner}, 32'd1);
    check("async_rst_timeout", {31'd0, bus.timeout}, 32'd0);
    drop(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_ack_in_reset", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
    end
    rst = 1'b1;
    bus.s_busy = 1'b0;
    push(1'b1, 1'b0, 32'h0, 3, 0, 1, 12'h005, 2'b00, 32'h000000A5);
    req(1'b1, 1'b1, 2'b00, 12'h005, 32'h000000A5);
    wait_ack(40, 1'b0, -1);

    // Completion on the same edge the counter reaches MAX_WAIT.
    bus.s_busy = 1'b1; bus.s_rdata = 32'h12345678;
    push(1'b0, 1'b0, 32'h12345678, 3 + MW, 1, 0, 12'h100, 2'b10, 32'h0);
    req(1'b0, 1'b0, 2'b10, 12'h100, 32'h0);
    wait_ack(40, 1'b0, MW + 1);
    check("timeout_not_set", {31'd0, bus.timeout}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
